// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants and types for the hazard/forwarding unit
// Holds store opcodes, forward-select encodings and the load-use stall FSM state type.
package hazard_pkg;

   // Store opcodes; their data operand may need forwarding from WB.
   localparam logic [5:0] OP_SW = 6'b101011;
   localparam logic [5:0] OP_SH = 6'b101001;
   localparam logic [5:0] OP_SB = 6'b101000;

   // Operand mux selects; 0x means "use the decoder default".
   localparam logic [1:0] FWD_MEM = 2'b11;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } stall_state_t;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - MEM/WB-priority operand forward select for one source register
// Ports:
//   src            source register of the EX instruction
//   mem_write_reg  destination in MEM, mem_reg_write its write enable
//   wb_write_reg   destination in WB,  wb_reg_write  its write enable
//   fwd_en         forwarding allowed for this operand
//   dflt           decoder default select bit
//   sel            11 = MEM, 10 = WB, {0,dflt} otherwise
module fwd_select
   import hazard_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] mem_write_reg,
   input  logic              mem_reg_write,
   input  logic [ADDR_W-1:0] wb_write_reg,
   input  logic              wb_reg_write,
   input  logic              fwd_en,
   input  logic              dflt,
   output logic [1:0]        sel
);

   logic mem_match;
   logic wb_match;

   // Register 0 is hardwired to zero, so a write to it never produces a value.
   assign mem_match = mem_reg_write && (mem_write_reg == src) && (src != '0);
   assign wb_match  = wb_reg_write  && (wb_write_reg  == src) && (src != '0);

   always_comb begin
      sel = {1'b0, dflt};
      if (fwd_en) begin
         // MEM holds the younger result, so it wins over WB.
         if (mem_match) begin
            sel = FWD_MEM;
         end else if (wb_match) begin
            sel = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - operand/store-data forwarding and load-use stall control
// Ports:
//   Clk, Reset_n                 clock, synchronous active-low reset
//   ID_*                         sources of the instruction in ID
//   EX_*, MEM_*, WB_*            pipeline-register fields used for matching
//   ALUSrcSelect, ShiftSelect    decoder defaults for the ALU B / A muxes
//   Flush                        taken branch/jump, squashes ID
//   EX_Shift, EX_ALUSrc          A / B operand mux selects
//   MEM_WriteData, EX_WriteData  store-data forward from WB
//   PC_Write, IFID_Write         0 = hold PC / IF-ID
//   IDEX_Bubble                  1 = load NOP into ID/EX
//   Busy                         stall FSM in STALL
//   StallCount                   saturating count of stalled cycles
module hazard_forward_unit
   import hazard_pkg::*;
#(
   parameter int ADDR_W            = 5,
   parameter int OPC_W             = 6,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int CNT_W             = 16
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [ADDR_W-1:0] ID_Rs,
   input  logic [ADDR_W-1:0] ID_Rt,
   input  logic              ID_UsesRt,
   input  logic [ADDR_W-1:0] EX_Rs,
   input  logic [ADDR_W-1:0] EX_Rt,
   input  logic [ADDR_W-1:0] EX_WriteReg,
   input  logic              EX_RegWrite,
   input  logic              EX_MemRead,
   input  logic [OPC_W-1:0]  EX_OPCode,
   input  logic [OPC_W-1:0]  MEM_OPCode,
   input  logic [ADDR_W-1:0] MEM_Rt,
   input  logic [ADDR_W-1:0] MEM_WriteReg,
   input  logic [ADDR_W-1:0] WB_WriteReg,
   input  logic              MEM_RegWrite,
   input  logic              WB_RegWrite,
   input  logic              ALUSrcSelect,
   input  logic              ShiftSelect,
   input  logic              Flush,
   output logic [1:0]        EX_Shift,
   output logic [1:0]        EX_ALUSrc,
   output logic              MEM_WriteData,
   output logic              EX_WriteData,
   output logic              PC_Write,
   output logic              IFID_Write,
   output logic              IDEX_Bubble,
   output logic              Busy,
   output logic [CNT_W-1:0]  StallCount
);

   localparam logic [2:0] REM_INIT = 3'(LOAD_STALL_CYCLES - 1);

   stall_state_t     state;
   stall_state_t     state_nxt;
   stall_state_t     cur_state;
   logic [2:0]       rem;
   logic [2:0]       rem_nxt;
   logic             hazard;
   logic             stall;
   logic             mem_is_store;
   logic             ex_is_store;
   logic             mem_rt_wb_match;
   logic             ex_rt_wb_match;

   // ---------------------------------------------------------------
   // Operand forwarding
   // ---------------------------------------------------------------
   fwd_select #(.ADDR_W(ADDR_W)) u_fwd_rs (
      .src           (EX_Rs),
      .mem_write_reg (MEM_WriteReg),
      .mem_reg_write (MEM_RegWrite),
      .wb_write_reg  (WB_WriteReg),
      .wb_reg_write  (WB_RegWrite),
      .fwd_en        (1'b1),
      .dflt          (ShiftSelect),
      .sel           (EX_Shift)
   );

   // An immediate B operand (ALUSrcSelect=1) must never be overridden by a forward.
   fwd_select #(.ADDR_W(ADDR_W)) u_fwd_rt (
      .src           (EX_Rt),
      .mem_write_reg (MEM_WriteReg),
      .mem_reg_write (MEM_RegWrite),
      .wb_write_reg  (WB_WriteReg),
      .wb_reg_write  (WB_RegWrite),
      .fwd_en        (!ALUSrcSelect),
      .dflt          (ALUSrcSelect),
      .sel           (EX_ALUSrc)
   );

   // ---------------------------------------------------------------
   // Store-data forwarding from WB
   // ---------------------------------------------------------------
   assign mem_is_store = (MEM_OPCode == OPC_W'(OP_SW)) ||
                         (MEM_OPCode == OPC_W'(OP_SH)) ||
                         (MEM_OPCode == OPC_W'(OP_SB));
   assign ex_is_store  = (EX_OPCode == OPC_W'(OP_SW)) ||
                         (EX_OPCode == OPC_W'(OP_SH)) ||
                         (EX_OPCode == OPC_W'(OP_SB));

   assign mem_rt_wb_match = WB_RegWrite && (WB_WriteReg == MEM_Rt) && (MEM_Rt != '0);
   assign ex_rt_wb_match  = WB_RegWrite && (WB_WriteReg == EX_Rt)  && (EX_Rt  != '0);

   assign MEM_WriteData = mem_is_store && mem_rt_wb_match;
   assign EX_WriteData  = ex_is_store  && ex_rt_wb_match;

   // ---------------------------------------------------------------
   // Load-use stall controller
   // ---------------------------------------------------------------
   assign hazard = EX_MemRead && EX_RegWrite && (EX_WriteReg != '0) &&
                   ((EX_WriteReg == ID_Rs) || (ID_UsesRt && (EX_WriteReg == ID_Rt))) &&
                   !Flush;

   // While reset is held the stall outputs behave as if already back in IDLE.
   assign cur_state = Reset_n ? state : ST_IDLE;

   always_comb begin
      state_nxt = cur_state;
      rem_nxt   = rem;
      stall     = 1'b0;
      if (Flush) begin
         state_nxt = ST_IDLE;
         rem_nxt   = 3'd0;
      end else begin
         case (cur_state)
            ST_IDLE: begin
               if (hazard) begin
                  stall = 1'b1;
                  if (LOAD_STALL_CYCLES > 1) begin
                     state_nxt = ST_STALL;
                     rem_nxt   = REM_INIT;
                  end
               end
            end
            ST_STALL: begin
               // Hazard detection is suspended here; the EX load is still in flight.
               stall   = 1'b1;
               rem_nxt = rem - 3'd1;
               if (rem <= 3'd1) begin
                  state_nxt = ST_IDLE;
                  rem_nxt   = 3'd0;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               rem_nxt   = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state      <= ST_IDLE;
         rem        <= 3'd0;
         StallCount <= '0;
      end else begin
         state <= state_nxt;
         rem   <= rem_nxt;
         if (stall && (StallCount != {CNT_W{1'b1}})) begin
            StallCount <= StallCount + CNT_W'(1);
         end
      end
   end

   assign PC_Write    = !stall;
   assign IFID_Write  = !stall;
   assign IDEX_Bubble = stall;
   assign Busy        = (cur_state == ST_STALL);

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed self-checking bench for hazard_forward_unit
module tb_hazard_forward_unit;

   logic       clk;
   logic       reset_n;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_write_reg, mem_rt, mem_write_reg, wb_write_reg;
   logic       id_uses_rt, ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
   logic [5:0] ex_opcode, mem_opcode;
   logic       alu_src_select, shift_select, flush;

   logic [1:0]  u1_shift, u1_alusrc, u3_shift, u3_alusrc, u5_shift, u5_alusrc;
   logic        u1_mwd, u1_ewd, u1_pcw, u1_ifw, u1_bub, u1_busy;
   logic        u3_mwd, u3_ewd, u3_pcw, u3_ifw, u3_bub, u3_busy;
   logic        u5_mwd, u5_ewd, u5_pcw, u5_ifw, u5_bub, u5_busy;
   logic [15:0] u1_cnt, u3_cnt;
   logic [1:0]  u5_cnt;

   int checks   = 0;
   int failures = 0;

   hazard_forward_unit #(.LOAD_STALL_CYCLES(1)) u1 (
      .Clk(clk), .Reset_n(reset_n), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_uses_rt),
      .EX_Rs(ex_rs), .EX_Rt(ex_rt), .EX_WriteReg(ex_write_reg), .EX_RegWrite(ex_reg_write),
      .EX_MemRead(ex_mem_read), .EX_OPCode(ex_opcode), .MEM_OPCode(mem_opcode), .MEM_Rt(mem_rt),
      .MEM_WriteReg(mem_write_reg), .WB_WriteReg(wb_write_reg), .MEM_RegWrite(mem_reg_write),
      .WB_RegWrite(wb_reg_write), .ALUSrcSelect(alu_src_select), .ShiftSelect(shift_select),
      .Flush(flush), .EX_Shift(u1_shift), .EX_ALUSrc(u1_alusrc), .MEM_WriteData(u1_mwd),
      .EX_WriteData(u1_ewd), .PC_Write(u1_pcw), .IFID_Write(u1_ifw), .IDEX_Bubble(u1_bub),
      .Busy(u1_busy), .StallCount(u1_cnt)
   );

   hazard_forward_unit #(.LOAD_STALL_CYCLES(3)) u3 (
      .Clk(clk), .Reset_n(reset_n), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_uses_rt),
      .EX_Rs(ex_rs), .EX_Rt(ex_rt), .EX_WriteReg(ex_write_reg), .EX_RegWrite(ex_reg_write),
      .EX_MemRead(ex_mem_read), .EX_OPCode(ex_opcode), .MEM_OPCode(mem_opcode), .MEM_Rt(mem_rt),
      .MEM_WriteReg(mem_write_reg), .WB_WriteReg(wb_write_reg), .MEM_RegWrite(mem_reg_write),
      .WB_RegWrite(wb_reg_write), .ALUSrcSelect(alu_src_select), .ShiftSelect(shift_select),
      .Flush(flush), .EX_Shift(u3_shift), .EX_ALUSrc(u3_alusrc), .MEM_WriteData(u3_mwd),
      .EX_WriteData(u3_ewd), .PC_Write(u3_pcw), .IFID_Write(u3_ifw), .IDEX_Bubble(u3_bub),
      .Busy(u3_busy), .StallCount(u3_cnt)
   );

   hazard_forward_unit #(.LOAD_STALL_CYCLES(5), .CNT_W(2)) u5 (
      .Clk(clk), .Reset_n(reset_n), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_uses_rt),
      .EX_Rs(ex_rs), .EX_Rt(ex_rt), .EX_WriteReg(ex_write_reg), .EX_RegWrite(ex_reg_write),
      .EX_MemRead(ex_mem_read), .EX_OPCode(ex_opcode), .MEM_OPCode(mem_opcode), .MEM_Rt(mem_rt),
      .MEM_WriteReg(mem_write_reg), .WB_WriteReg(wb_write_reg), .MEM_RegWrite(mem_reg_write),
      .WB_RegWrite(wb_reg_write), .ALUSrcSelect(alu_src_select), .ShiftSelect(shift_select),
      .Flush(flush), .EX_Shift(u5_shift), .EX_ALUSrc(u5_alusrc), .MEM_WriteData(u5_mwd),
      .EX_WriteData(u5_ewd), .PC_Write(u5_pcw), .IFID_Write(u5_ifw), .IDEX_Bubble(u5_bub),
      .Busy(u5_busy), .StallCount(u5_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
      ex_rs = '0; ex_rt = '0; ex_write_reg = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
      ex_opcode = '0; mem_opcode = '0; mem_rt = '0;
      mem_write_reg = '0; wb_write_reg = '0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
      alu_src_select = 1'b0; shift_select = 1'b0; flush = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
   endtask

   task automatic load_hazard_r7();
      ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_write_reg = 5'd7; id_rs = 5'd7;
   endtask

   task automatic clear_hazard();
      ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_write_reg = '0; id_rs = '0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset_n = 1'b0;
      step(); step();
      checks++; if (u1_pcw !== 1'b1) begin failures++; $display("FAIL reset_pc_write got=%0b exp=1", u1_pcw); end
      checks++; if (u1_bub !== 1'b0) begin failures++; $display("FAIL reset_bubble got=%0b exp=0", u1_bub); end
      checks++; if (u3_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", u3_busy); end
      checks++; if (u3_cnt !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", u3_cnt); end
      checks++; if (u1_shift !== 2'b00) begin failures++; $display("FAIL reset_shift got=%b exp=00", u1_shift); end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_fwd_rs();
      clear_inputs();
      ex_rs = 5'd3; mem_write_reg = 5'd3; mem_reg_write = 1'b1; wb_write_reg = 5'd3; wb_reg_write = 1'b1;
      #1;
      checks++; if (u1_shift !== 2'b11) begin failures++; $display("FAIL rs_mem_priority got=%b exp=11", u1_shift); end
      mem_reg_write = 1'b0;
      #1;
      checks++; if (u1_shift !== 2'b10) begin failures++; $display("FAIL rs_wb got=%b exp=10", u1_shift); end
      wb_reg_write = 1'b0; shift_select = 1'b1;
      #1;
      checks++; if (u1_shift !== 2'b01) begin failures++; $display("FAIL rs_default got=%b exp=01", u1_shift); end
      step();
   endtask

   task automatic test_fwd_rt_r0();
      clear_inputs();
      ex_rt = 5'd0; mem_write_reg = 5'd0; mem_reg_write = 1'b1; alu_src_select = 1'b0;
      #1;
      checks++; if (u1_alusrc !== 2'b00) begin failures++; $display("FAIL rt_r0_noforward got=%b exp=00", u1_alusrc); end
      alu_src_select = 1'b1;
      #1;
      checks++; if (u1_alusrc !== 2'b01) begin failures++; $display("FAIL rt_r0_imm got=%b exp=01", u1_alusrc); end
      ex_rt = 5'd4; mem_write_reg = 5'd4;
      #1;
      checks++; if (u1_alusrc !== 2'b01) begin failures++; $display("FAIL rt_imm_blocks_fwd got=%b exp=01", u1_alusrc); end
      alu_src_select = 1'b0;
      #1;
      checks++; if (u1_alusrc !== 2'b11) begin failures++; $display("FAIL rt_mem got=%b exp=11", u1_alusrc); end
      step();
   endtask

   task automatic test_store_fwd();
      clear_inputs();
      mem_opcode = 6'b101011; mem_rt = 5'd5; ex_opcode = 6'b101000; ex_rt = 5'd5;
      wb_write_reg = 5'd5; wb_reg_write = 1'b1;
      #1;
      checks++; if (u1_mwd !== 1'b1) begin failures++; $display("FAIL store_mem_wd got=%0b exp=1", u1_mwd); end
      checks++; if (u1_ewd !== 1'b1) begin failures++; $display("FAIL store_ex_wd got=%0b exp=1", u1_ewd); end
      mem_opcode = 6'b100011; ex_opcode = 6'b101001;
      #1;
      checks++; if (u1_mwd !== 1'b0) begin failures++; $display("FAIL store_mem_load got=%0b exp=0", u1_mwd); end
      checks++; if (u1_ewd !== 1'b1) begin failures++; $display("FAIL store_ex_sh got=%0b exp=1", u1_ewd); end
      wb_reg_write = 1'b0;
      #1;
      checks++; if (u1_ewd !== 1'b0) begin failures++; $display("FAIL store_no_wb got=%0b exp=0", u1_ewd); end
      step();
   endtask

   task automatic test_hazard_conditions();
      do_reset();
      ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_write_reg = 5'd7;
      id_rs = 5'd2; id_rt = 5'd7; id_uses_rt = 1'b1;
      #1;
      checks++; if (u1_bub !== 1'b1) begin failures++; $display("FAIL haz_rt got=%0b exp=1", u1_bub); end
      id_uses_rt = 1'b0;
      #1;
      checks++; if (u1_bub !== 1'b0) begin failures++; $display("FAIL haz_rt_unused got=%0b exp=0", u1_bub); end
      ex_write_reg = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
      #1;
      checks++; if (u1_bub !== 1'b0) begin failures++; $display("FAIL haz_r0 got=%0b exp=0", u1_bub); end
      ex_write_reg = 5'd7; id_rs = 5'd7; ex_reg_write = 1'b0;
      #1;
      checks++; if (u1_bub !== 1'b0) begin failures++; $display("FAIL haz_no_regwrite got=%0b exp=0", u1_bub); end
      clear_inputs();
      step();
   endtask

   task automatic test_stall_single();
      do_reset();
      load_hazard_r7();
      #1;
      checks++; if ({u1_pcw, u1_ifw, u1_bub} !== 3'b001) begin failures++; $display("FAIL s1_active got=%b exp=001", {u1_pcw, u1_ifw, u1_bub}); end
      checks++; if (u1_busy !== 1'b0) begin failures++; $display("FAIL s1_busy got=%0b exp=0", u1_busy); end
      step();
      clear_hazard();
      #1;
      checks++; if ({u1_pcw, u1_ifw, u1_bub} !== 3'b110) begin failures++; $display("FAIL s1_released got=%b exp=110", {u1_pcw, u1_ifw, u1_bub}); end
      checks++; if (u1_cnt !== 16'd1) begin failures++; $display("FAIL s1_count got=%0d exp=1", u1_cnt); end
      checks++; if (u1_busy !== 1'b0) begin failures++; $display("FAIL s1_busy_after got=%0b exp=0", u1_busy); end
      repeat (6) step();
   endtask

   task automatic test_stall_multi();
      do_reset();
      load_hazard_r7();
      #1;
      checks++; if (u3_bub !== 1'b1 || u3_busy !== 1'b0) begin failures++; $display("FAIL s3_c1 got=bub%0b busy%0b exp=bub1 busy0", u3_bub, u3_busy); end
      step();
      clear_hazard();
      #1;
      checks++; if (u3_busy !== 1'b1 || u3_pcw !== 1'b0) begin failures++; $display("FAIL s3_c2 got=busy%0b pcw%0b exp=busy1 pcw0", u3_busy, u3_pcw); end
      step();
      checks++; if (u3_busy !== 1'b1 || u3_ifw !== 1'b0 || u3_cnt !== 16'd2) begin failures++; $display("FAIL s3_c3 got=busy%0b ifw%0b cnt%0d exp=busy1 ifw0 cnt2", u3_busy, u3_ifw, u3_cnt); end
      step();
      checks++; if (u3_busy !== 1'b0 || u3_pcw !== 1'b1) begin failures++; $display("FAIL s3_done got=busy%0b pcw%0b exp=busy0 pcw1", u3_busy, u3_pcw); end
      checks++; if (u3_cnt !== 16'd3) begin failures++; $display("FAIL s3_count got=%0d exp=3", u3_cnt); end
      repeat (4) step();
   endtask

   task automatic test_saturation();
      do_reset();
      load_hazard_r7();
      step();
      clear_hazard();
      step();
      checks++; if (u5_cnt !== 2'd2) begin failures++; $display("FAIL sat_c2 got=%0d exp=2", u5_cnt); end
      step();
      checks++; if (u5_cnt !== 2'd3) begin failures++; $display("FAIL sat_c3 got=%0d exp=3", u5_cnt); end
      step();
      checks++; if (u5_cnt !== 2'd3 || u5_busy !== 1'b1) begin failures++; $display("FAIL sat_hold got=cnt%0d busy%0b exp=cnt3 busy1", u5_cnt, u5_busy); end
      step();
      checks++; if (u5_cnt !== 2'd3 || u5_busy !== 1'b0 || u5_pcw !== 1'b1) begin failures++; $display("FAIL sat_end got=cnt%0d busy%0b pcw%0b exp=cnt3 busy0 pcw1", u5_cnt, u5_busy, u5_pcw); end
      step();
   endtask

   task automatic test_flush();
      do_reset();
      load_hazard_r7();
      step();
      clear_hazard();
      flush = 1'b1;
      #1;
      checks++; if ({u3_pcw, u3_ifw, u3_bub} !== 3'b110) begin failures++; $display("FAIL flush_stall_out got=%b exp=110", {u3_pcw, u3_ifw, u3_bub}); end
      step();
      flush = 1'b0;
      #1;
      checks++; if (u3_busy !== 1'b0 || u3_cnt !== 16'd1) begin failures++; $display("FAIL flush_end got=busy%0b cnt%0d exp=busy0 cnt1", u3_busy, u3_cnt); end
      load_hazard_r7();
      flush = 1'b1;
      #1;
      checks++; if (u1_bub !== 1'b0 || u1_pcw !== 1'b1) begin failures++; $display("FAIL flush_idle got=bub%0b pcw%0b exp=bub0 pcw1", u1_bub, u1_pcw); end
      step();
      clear_hazard();
      flush = 1'b0;
      #1;
      checks++; if (u1_cnt !== 16'd1) begin failures++; $display("FAIL flush_idle_count got=%0d exp=1", u1_cnt); end
      step();
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      load_hazard_r7();
      step();
      clear_hazard();
      #1;
      checks++; if (u3_busy !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got=%0b exp=1", u3_busy); end
      reset_n = 1'b0;
      #1;
      checks++; if (u3_busy !== 1'b0 || u3_pcw !== 1'b1) begin failures++; $display("FAIL rst_mid_during got=busy%0b pcw%0b exp=busy0 pcw1", u3_busy, u3_pcw); end
      step();
      reset_n = 1'b1;
      #1;
      checks++; if (u3_busy !== 1'b0 || u3_cnt !== 16'd0) begin failures++; $display("FAIL rst_mid_after got=busy%0b cnt%0d exp=busy0 cnt0", u3_busy, u3_cnt); end
      step();
      checks++; if (u3_pcw !== 1'b1 || u3_cnt !== 16'd0) begin failures++; $display("FAIL rst_mid_aborted got=pcw%0b cnt%0d exp=pcw1 cnt0", u3_pcw, u3_cnt); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      load_hazard_r7();
      step();
      step();
      checks++; if (u3_busy !== 1'b1) begin failures++; $display("FAIL b2b_c3 got=%0b exp=1", u3_busy); end
      step();
      checks++; if (u3_busy !== 1'b0 || u3_bub !== 1'b1 || u3_cnt !== 16'd3) begin failures++; $display("FAIL b2b_c4 got=busy%0b bub%0b cnt%0d exp=busy0 bub1 cnt3", u3_busy, u3_bub, u3_cnt); end
      step();
      checks++; if (u3_busy !== 1'b1 || u3_cnt !== 16'd4) begin failures++; $display("FAIL b2b_c5 got=busy%0b cnt%0d exp=busy1 cnt4", u3_busy, u3_cnt); end
      clear_hazard();
      repeat (6) step();
   endtask

   initial begin
      reset_n = 1'b0;
      clear_inputs();
      test_reset();
      test_fwd_rs();
      test_fwd_rt_r0();
      test_store_fwd();
      test_hazard_conditions();
      test_stall_single();
      test_stall_multi();
      test_saturation();
      test_flush();
      test_reset_mid_stall();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
